// File: rtl/multiplier_block_seq.sv
// multiplier_block_seq: sequential shift-add constant multiplier.
// Computes o_data0 = (i_data0 * coefficient) mod 2^WIDTH. It adds at most one
// partial product per clock and has a valid/ready handshake on each side.
// Optional feature macro: MULTIPLIER_BLOCK_SEQ_RUNTIME_COEFF_EN
//   defined   -> the coefficient is sampled from i_coeff when an operand is accepted
//   undefined -> the coefficient is the COEFF parameter and i_coeff is ignored
module multiplier_block_seq #(
    parameter int          WIDTH  = 32,
    parameter int          CWIDTH = 16,
    parameter int unsigned COEFF  = 24465
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [WIDTH-1:0]  i_data0,
    input  logic [CWIDTH-1:0] i_coeff,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [WIDTH-1:0]  o_data0,
    output logic              o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [CWIDTH-1:0]  b_q, b_d;
    logic               valid_q, valid_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;

    logic [CWIDTH-1:0]  coeff_sel_s;
    logic [WIDTH-1:0]   acc_sum_s;
    logic               last_step_s;

`ifdef MULTIPLIER_BLOCK_SEQ_RUNTIME_COEFF_EN
    // The coefficient comes from the port. It is only used in the accept cycle.
    assign coeff_sel_s = i_coeff;
`else
    localparam logic [CWIDTH-1:0] COEFF_C = CWIDTH'(COEFF);
    // The port is kept for interface compatibility. Its value has no effect.
    logic unused_coeff_s;
    assign unused_coeff_s = ^i_coeff;
    assign coeff_sel_s    = COEFF_C;
`endif

    // Partial-product add for the current coefficient bit. The sum wraps mod 2^WIDTH.
    always_comb begin
        acc_sum_s = acc_q;
        if (b_q[0]) begin
            acc_sum_s = acc_q + a_q;
        end else begin
            acc_sum_s = acc_q;
        end
    end

    // This is the final step when no set coefficient bits remain above bit 0.
    assign last_step_s = ((b_q >> 1) == {CWIDTH{1'b0}});

    // Next-state, datapath and registered output values for the handshake FSM.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        data_d  = data_q;

        case (state_q)
            ST_IDLE: begin
                if (i_valid && ready_q) begin
                    a_d     = i_data0;
                    b_d     = coeff_sel_s;
                    acc_d   = {WIDTH{1'b0}};
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_d = acc_sum_s;
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                if (last_step_s) begin
                    data_d  = acc_sum_s;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                // Completing the handshake returns to IDLE. The handshake cycle cannot accept an operand.
                if (i_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        valid_d = (state_d == ST_DONE);
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
    end

    // State, datapath and output registers. Synchronous reset discards any in-flight operation.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {CWIDTH{1'b0}};
            acc_q   <= {WIDTH{1'b0}};
            data_q  <= {WIDTH{1'b0}};
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign o_ready = ready_q;
    assign o_valid = valid_q;
    assign o_busy  = busy_q;
    assign o_data0 = data_q;

endmodule

// File: tb/tb_multiplier_block_seq.sv
// Scoreboard testbench for multiplier_block_seq. The stimulus pushes the
// expected products into a queue. A monitor pops and compares them at each
// output handshake.
module tb_multiplier_block_seq;

    localparam int W  = 32;
    localparam int CW = 16;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_valid;
    logic          o_ready;
    logic [W-1:0]  i_data0;
    logic [CW-1:0] i_coeff;
    logic          o_valid;
    logic          i_ready;
    logic [W-1:0]  o_data0;
    logic          o_busy;

`ifdef MULTIPLIER_BLOCK_SEQ_RUNTIME_COEFF_EN
    localparam logic [CW-1:0] C_DEF = 16'd24465;
`else
    localparam logic [CW-1:0] C_DEF = 16'd0;
`endif

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [W-1:0] exp_q[$];

    multiplier_block_seq #(.WIDTH(W), .CWIDTH(CW), .COEFF(24465)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data0 (i_data0),
        .i_coeff (i_coeff),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data0 (o_data0),
        .o_busy  (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compare every output handshake against the scoreboard head.
    always @(negedge i_clk) begin
        if (!i_rst && o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: got 0x%08h expected no result", o_data0);
            end else begin
                check("sb_result", o_data0, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Wait for IDLE, then present one operand. Returns 1 time unit after the accept edge.
    task automatic accept(input logic [W-1:0] d, input logic [CW-1:0] c);
        int n = 0;
        while (!o_ready && n < 200) begin
            tick();
            n++;
        end
        check("ready_before_accept", W'(o_ready), 32'd1);
        i_data0 = d;
        i_coeff = c;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        i_coeff = ~c;   // later coefficient changes must not affect the running operation
        check("busy_after_accept", W'(o_busy), 32'd1);
        check("ready_low_in_run", W'(o_ready), 32'd0);
    endtask

    task automatic wait_valid(input string name, input int exp_len);
        int n = 0;
        while (!o_valid && n < 100) begin
            tick();
            n++;
        end
        check(name, W'(n), W'(exp_len));
    endtask

    // Run one operation with optional backpressure. The handshake cycle presents a competing operand.
    task automatic do_op(input string name, input logic [W-1:0] d, input logic [CW-1:0] c,
                         input logic [W-1:0] exp, input int len, input int hold);
        i_ready = (hold == 0);
        exp_q.push_back(exp);
        accept(d, c);
        wait_valid({name, "_latency"}, len);
        for (int k = 0; k < hold; k++) begin
            i_valid = 1'b1;
            i_data0 = ~d;
            tick();
            check({name, "_hold_valid"}, W'(o_valid), 32'd1);
            check({name, "_hold_data"}, o_data0, exp);
            check({name, "_hold_ready"}, W'(o_ready), 32'd0);
        end
        i_ready = 1'b1;
        i_valid = 1'b1;
        i_data0 = ~d;
        tick();
        i_valid = 1'b0;
        check({name, "_idle_valid"}, W'(o_valid), 32'd0);
        check({name, "_idle_ready"}, W'(o_ready), 32'd1);
        check({name, "_idle_busy"}, W'(o_busy), 32'd0);
        check({name, "_retain"}, o_data0, exp);
    endtask

    initial begin
        int n;
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_data0 = 32'd0;
        i_coeff = C_DEF;
        tick();
        tick();
        check("rst_ready", W'(o_ready), 32'd1);
        check("rst_valid", W'(o_valid), 32'd0);
        check("rst_busy", W'(o_busy), 32'd0);
        check("rst_data", o_data0, 32'd0);
        i_rst = 1'b0;
        tick();

        // Basic product and wraparound.
        do_op("one",  32'd1,          C_DEF, 32'h0000_5F91, 15, 0);
        do_op("wrap", 32'hFFFF_FFFF,  C_DEF, 32'hFFFF_A06F, 15, 0);
        // Backpressure for 5 cycles.
        do_op("bp",   32'd3,          C_DEF, 32'd73395,     15, 5);

        // Reset during RUN cycle 7 drops the operation.
        i_ready = 1'b1;
        accept(32'd5, C_DEF);
        repeat (6) tick();
        check("mid_run_busy", W'(o_busy), 32'd1);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check("midrst_valid", W'(o_valid), 32'd0);
        check("midrst_data", o_data0, 32'd0);
        check("midrst_ready", W'(o_ready), 32'd1);
        check("midrst_busy", W'(o_busy), 32'd0);
        do_op("after_rst", 32'd2, C_DEF, 32'd48930, 15, 0);

`ifdef MULTIPLIER_BLOCK_SEQ_RUNTIME_COEFF_EN
        do_op("rc_zero", 32'h1234, 16'h0000, 32'd0,        1,  0);
        do_op("rc_one",  32'h1234, 16'h0001, 32'h1234,     1,  0);
        do_op("rc_full", 32'd3,    16'hFFFF, 32'h0002_FFFD, 16, 0);
`endif

        // Back-to-back operands with i_valid held high.
        i_ready = 1'b1;
        n = 0;
        while (!o_ready && n < 100) begin
            tick();
            n++;
        end
        exp_q.push_back(32'd122325);
        exp_q.push_back(32'd171255);
        i_coeff = C_DEF;
        i_data0 = 32'd5;
        i_valid = 1'b1;
        tick();
        i_data0 = 32'd7;
        n = 0;
        while (!o_ready && n < 100) begin
            tick();
            n++;
        end
        check("b2b_gap", W'(n), 32'd16);
        tick();
        i_valid = 1'b0;
        check("b2b_second_accept", W'(o_busy), 32'd1);
        wait_valid("b2b_latency", 15);
        tick();
        check("b2b_idle", W'(o_ready), 32'd1);

        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            tick();
            n++;
        end
        check("sb_drain", W'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
